// File: rtl/dtc_walk_ctrl.sv
// Sequential decision-tree walker: programmable node table, one node per clock.
// Optional macro DTC_WALK_PERF_EN adds perf_nodes / perf_cnt observability outputs.
module dtc_walk_ctrl #(
  parameter int IN_W      = 10,
  parameter int OUT_W     = 10,
  parameter int NODES     = 16,
  parameter int AW        = 4,
  parameter int FW        = 4,
  parameter int MAX_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  inp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] outp,
  output logic             out_err,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic             cfg_leaf,
  input  logic [FW-1:0]    cfg_feat,
  input  logic [AW-1:0]    cfg_lo,
  input  logic [AW-1:0]    cfg_hi,
  input  logic [OUT_W-1:0] cfg_val,
  output logic             busy
`ifdef DTC_WALK_PERF_EN
  ,
  output logic [AW:0]      perf_nodes,
  output logic [31:0]      perf_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for a sample, table writable
  // WALK  | visiting one node per cycle
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  localparam int SW = $clog2(MAX_DEPTH + 1);
  localparam int PW = 2 ** FW;

  state_t r_state, w_next;

  logic             r_leaf [NODES];
  logic [FW-1:0]    r_feat [NODES];
  logic [AW-1:0]    r_lo   [NODES];
  logic [AW-1:0]    r_hi   [NODES];
  logic [OUT_W-1:0] r_val  [NODES];

  logic [IN_W-1:0]  r_sample;
  logic [AW-1:0]    r_ptr;
  logic [SW-1:0]    r_steps;
  logic [OUT_W-1:0] r_outp;
  logic             r_err;

  logic             w_leaf;
  logic [FW-1:0]    w_feat;
  logic [PW-1:0]    w_pad;
  logic             w_bit;
  logic             w_last;
  logic             w_cfg_wr;

  assign w_leaf   = r_leaf[r_ptr];
  assign w_feat   = r_feat[r_ptr];
  // Zero-padding the sample makes out-of-range feature indices read as 0.
  assign w_pad    = {{(PW - IN_W){1'b0}}, r_sample};
  assign w_bit    = w_pad[w_feat];
  assign w_last   = (r_steps == SW'(MAX_DEPTH - 1));
  assign w_cfg_wr = (r_state == IDLE) && cfg_we;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign outp      = r_outp;
  assign out_err   = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = WALK;
      WALK:    if (w_leaf || w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) begin
        r_leaf[i] <= 1'b1;
        r_feat[i] <= '0;
        r_lo[i]   <= '0;
        r_hi[i]   <= '0;
        r_val[i]  <= '0;
      end
      r_sample <= '0;
      r_ptr    <= '0;
      r_steps  <= '0;
      r_outp   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_cfg_wr) begin
        r_leaf[cfg_addr] <= cfg_leaf;
        r_feat[cfg_addr] <= cfg_feat;
        r_lo[cfg_addr]   <= cfg_lo;
        r_hi[cfg_addr]   <= cfg_hi;
        r_val[cfg_addr]  <= cfg_val;
      end
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sample <= inp;
            r_ptr    <= '0;
            r_steps  <= '0;
          end
        end
        WALK: begin
          if (w_leaf) begin
            r_outp <= r_val[r_ptr];
            r_err  <= 1'b0;
          end else if (w_last) begin
            r_outp <= '0;
            r_err  <= 1'b1;
          end else begin
            r_ptr   <= w_bit ? r_hi[r_ptr] : r_lo[r_ptr];
            r_steps <= r_steps + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DTC_WALK_PERF_EN
  logic [AW:0] r_nodes;
  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nodes <= '0;
      r_cnt   <= '0;
    end else begin
      // On abort steps is MAX_DEPTH-1, so steps+1 covers both outcomes.
      if ((r_state == WALK) && (w_leaf || w_last))
        r_nodes <= (AW+1)'(r_steps + 1'b1);
      if ((r_state == DONE) && out_ready && (r_cnt != 32'hFFFF_FFFF))
        r_cnt <= r_cnt + 32'd1;
    end
  end

  assign perf_nodes = r_nodes;
  assign perf_cnt   = r_cnt;
`endif

endmodule
